// File: rtl/remote_cmd_sequencer.sv
// remote_cmd_sequencer: drains a FIFO of {command, expected response} pairs over a remote link, checking each reply with timeout and retry
// Ports: push/push_cmd/push_exp/full load the FIFO; start/halt_on_err control a run;
// cmd/send_cmd/cmd_sent/resp_rdy/resp talk to the transmitter; busy/done/pass/err_cnt/err_code/cmd_idx report status.
module remote_cmd_sequencer #(
  parameter int DEPTH     = 8,
  parameter int CMD_W     = 16,
  parameter int RESP_W    = 8,
  parameter int TMO_CYC   = 1000000,
  parameter int MAX_RETRY = 2
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [CMD_W-1:0]         push_cmd,
  input  logic [RESP_W-1:0]        push_exp,
  output logic                     full,
  input  logic                     start,
  input  logic                     halt_on_err,
  output logic [CMD_W-1:0]         cmd,
  output logic                     send_cmd,
  input  logic                     cmd_sent,
  input  logic                     resp_rdy,
  input  logic [RESP_W-1:0]        resp,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [7:0]               err_cnt,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH):0]   cmd_idx
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TMO_CYC);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT_SENT, S_WAIT_RESP, S_CHECK, S_FIN} state_t;
  state_t r_state, w_next;
  logic [CMD_W-1:0]  r_mem_cmd [DEPTH];
  logic [RESP_W-1:0] r_mem_exp [DEPTH];
  logic [AW:0]       r_wp, r_rp;
  logic [CMD_W-1:0]  r_cmd;
  logic [RESP_W-1:0] r_exp, r_resp;
  logic [TW-1:0]     r_tmo;
  logic [2:0]        r_retry;
  logic              r_exh, r_pass;
  logic [7:0]        r_err_cnt;
  logic [1:0]        r_err_code;
  logic [AW:0]       r_cmd_idx;
  logic w_empty, w_push, w_tmo, w_retry_ok, w_fail;
  assign w_empty    = r_wp == r_rp;
  assign full       = (r_wp - r_rp) == (AW+1)'(DEPTH);
  assign w_push     = push && !full;
  assign w_tmo      = r_tmo == TW'(TMO_CYC - 1);
  assign w_retry_ok = int'(r_retry) < MAX_RETRY;
  // an exhausted command fails regardless of whatever stale response was latched
  assign w_fail     = r_exh || (r_resp != r_exp);
  assign cmd      = r_cmd;
  assign send_cmd = r_state == S_SEND;
  assign busy     = r_state != S_IDLE;
  assign done     = r_state == S_FIN;
  assign pass     = r_pass;
  assign err_cnt  = r_err_cnt;
  assign err_code = r_err_code;
  assign cmd_idx  = r_cmd_idx;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = start ? S_LOAD : S_IDLE;
      S_LOAD:      w_next = w_empty ? S_FIN : S_SEND;
      S_SEND:      w_next = S_WAIT_SENT;
      S_WAIT_SENT: w_next = cmd_sent ? S_WAIT_RESP : S_WAIT_SENT;
      // a response in the expiry cycle still wins over the timeout
      S_WAIT_RESP: w_next = resp_rdy ? S_CHECK : !w_tmo ? S_WAIT_RESP : w_retry_ok ? S_SEND : S_CHECK;
      S_CHECK:     w_next = (w_fail && halt_on_err) ? S_FIN : S_LOAD;
      S_FIN:       w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (w_push) begin
      r_mem_cmd[r_wp[AW-1:0]] <= push_cmd;
      r_mem_exp[r_wp[AW-1:0]] <= push_exp;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= S_IDLE;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cmd      <= '0;
      r_exp      <= '0;
      r_resp     <= '0;
      r_tmo      <= '0;
      r_retry    <= '0;
      r_exh      <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= '0;
      r_err_code <= '0;
      r_cmd_idx  <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      case (r_state)
        S_IDLE: if (start) begin
          r_err_cnt  <= '0;
          r_err_code <= '0;
          r_cmd_idx  <= '0;
          r_pass     <= 1'b0;
        end
        S_LOAD: if (!w_empty) begin
          r_cmd   <= r_mem_cmd[r_rp[AW-1:0]];
          r_exp   <= r_mem_exp[r_rp[AW-1:0]];
          r_exh   <= 1'b0;
          r_retry <= '0;
        end
        S_WAIT_SENT: if (cmd_sent) r_tmo <= '0;
        S_WAIT_RESP:
          if (resp_rdy) r_resp <= resp;
          else if (w_tmo) begin
            if (w_retry_ok) r_retry <= r_retry + 3'd1;
            else r_exh <= 1'b1;
          end else r_tmo <= r_tmo + TW'(1);
        S_CHECK: begin
          // the head is popped only here, so every retry resends the same entry
          r_rp      <= r_rp + (AW+1)'(1);
          r_cmd_idx <= r_cmd_idx + (AW+1)'(1);
          r_retry   <= '0;
          if (w_fail) begin
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            if (r_err_code == 2'b00) r_err_code <= r_exh ? 2'b11 : 2'b01;
          end
        end
        S_FIN: r_pass <= r_err_cnt == 8'd0;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_remote_cmd_sequencer.sv
// tb_remote_cmd_sequencer: directed and randomized runs checked against a queue-based reference model
module tb_remote_cmd_sequencer;
  localparam int DEPTH = 4, TMO = 20, MR = 2, BND = TMO + 40;
  logic clk = 1'b0, rst = 1'b1, push = 1'b0, start = 1'b0, halt_on_err = 1'b0, cmd_sent = 1'b0, resp_rdy = 1'b0;
  logic [15:0] push_cmd = '0, cmd;
  logic [7:0] push_exp = '0, resp = '0, err_cnt;
  logic full, send_cmd, busy, done, pass;
  logic [1:0] err_code;
  logic [2:0] cmd_idx;
  int n_chk = 0, n_err = 0;
  logic [23:0] q[$];
  int f_nto[$];
  bit f_match[$];

  remote_cmd_sequencer #(.DEPTH(DEPTH), .CMD_W(16), .RESP_W(8), .TMO_CYC(TMO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .push_exp(push_exp), .full(full),
    .start(start), .halt_on_err(halt_on_err), .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
    .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .err_code(err_code), .cmd_idx(cmd_idx));

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_push(input logic [15:0] c, input logic [7:0] e);
    check("full", full, q.size() == DEPTH);
    push = 1'b1; push_cmd = c; push_exp = e;
    if (q.size() < DEPTH) q.push_back({c, e});
    tick();
    push = 1'b0;
  endtask

  task automatic wait_send(output int lat, output bit ok);
    ok = 0; lat = 0;
    for (int i = 0; i < BND; i++) begin
      if (send_cmd) begin ok = 1; break; end
      tick(); lat++;
    end
    check("send_seen", ok, 1);
  endtask

  // Reference: each command is tried up to MR+1 times; the planned attempt nto answers
  // (match or not), and nto > MR means no attempt is answered and the command is exhausted.
  task automatic run(input bit halt);
    int nto, lat, m_cnt, m_code, m_idx, dly;
    bit m, ok, stop, first, rnd, fail;
    logic [23:0] h;
    rnd = f_nto.size() == 0;
    m_cnt = 0; m_code = 0; m_idx = 0; stop = 0; first = 1;
    halt_on_err = halt;
    start = 1'b1; tick(); start = 1'b0;
    while (q.size() > 0 && !stop) begin
      h = q[0];
      if (!rnd && f_nto.size() > 0) begin nto = f_nto.pop_front(); m = f_match.pop_front(); end
      else begin nto = $urandom_range(0, MR + 1); m = $urandom_range(0, 2) != 0; end
      for (int a = 0; a <= nto && a <= MR; a++) begin
        wait_send(lat, ok);
        if (!ok) return;
        if (first) check("start_latency", lat + 1, 2);
        first = 0;
        check("cmd", cmd, h[23:8]);
        tick();
        check("send_one_cycle", send_cmd, 0);
        if (rnd) repeat ($urandom_range(0, 3)) begin
          case ($urandom_range(0, 3))
            0: begin resp_rdy = 1'b1; resp = ~h[7:0]; tick(); resp_rdy = 1'b0; end
            1: do_push(16'($urandom), 8'($urandom));
            default: tick();
          endcase
        end
        cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
        if (a == nto) begin
          dly = !rnd ? 2 : ($urandom_range(0, 3) == 0) ? TMO - 1 : $urandom_range(0, TMO - 1);
          tick(dly);
          resp_rdy = 1'b1; resp = m ? h[7:0] : h[7:0] ^ 8'hFF;
          tick();
          resp_rdy = 1'b0;
        end
      end
      fail = nto > MR || !m;
      m_idx++;
      void'(q.pop_front());
      if (fail) begin
        if (m_cnt < 255) m_cnt++;
        if (m_code == 0) m_code = nto > MR ? 3 : 1;
        if (halt) stop = 1;
      end
    end
    ok = 0;
    for (int i = 0; i < BND; i++) begin
      if (done) begin ok = 1; break; end
      if (send_cmd) check("extra_send", send_cmd, 0);
      tick();
    end
    check("done", ok, 1);
    check("err_cnt", err_cnt, m_cnt);
    check("err_code", err_code, m_code);
    check("cmd_idx", cmd_idx, m_idx & 7);
    tick();
    check("done_one_cycle", done, 0);
    check("idle_after", busy, 0);
    check("pass", pass, m_cnt == 0);
  endtask

  initial begin
    bit seen;
    int lat;
    bit ok;
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_cmd", cmd, 0);
    rst = 1'b0;
    tick();
    // single matching command
    do_push(16'h2000, 8'hA5);
    f_nto = {0}; f_match = {1};
    run(0);
    // second command mismatches, run continues
    do_push(16'h2000, 8'hA5); do_push(16'h4BF1, 8'hA5);
    f_nto = {0, 0}; f_match = {1, 0};
    run(0);
    // halt on first mismatch, remaining entry resumes on next start
    do_push(16'h2000, 8'hA5); do_push(16'h4BF1, 8'hA5);
    f_nto = {0}; f_match = {0};
    run(1);
    check("halt_left", q.size(), 1);
    f_nto = {0}; f_match = {1};
    run(1);
    // never answered: three sends then exhausted
    do_push(16'h1234, 8'h77);
    f_nto = {3}; f_match = {1};
    run(0);
    // overfill: last push dropped
    for (int i = 0; i <= DEPTH; i++) do_push(16'h3000 + 16'(i), 8'(i));
    check("full_after", full, 1);
    f_nto = {0, 0, 0, 0}; f_match = {1, 1, 1, 1};
    run(0);
    // asynchronous reset while waiting for a response
    do_push(16'h1111, 8'h11); do_push(16'h2222, 8'h22);
    halt_on_err = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    wait_send(lat, ok);
    tick();
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    resp_rdy = 1'b1; resp = 8'h00; tick(); resp_rdy = 1'b0;
    wait_send(lat, ok);
    check("cmd2", cmd, 16'h2222);
    tick();
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    tick(3);
    check("pre_rst_err", err_cnt, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_send", send_cmd, 0);
    check("arst_cmd", cmd, 0);
    check("arst_err_cnt", err_cnt, 0);
    check("arst_err_code", err_code, 0);
    check("arst_idx", cmd_idx, 0);
    check("arst_pass", pass, 0);
    check("arst_full", full, 0);
    tick();
    rst = 1'b0;
    q.delete();
    seen = 0;
    repeat (5) begin seen |= done; tick(); end
    check("no_done_after_rst", seen, 0);
    run(0);
    // randomized runs
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, DEPTH + 1)) do_push(16'($urandom), 8'($urandom));
      run(1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/remote_cmd_sequencer.md
REMOTE_CMD_SEQUENCER -- requirements
Module: remote_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: command FIFO entries, power of two, 2..64.
REQ-002 Parameter CMD_W, default 16: command width.
REQ-003 Parameter RESP_W, default 8: response width.
REQ-004 Parameter TMO_CYC, default 1000000: response timeout in clk cycles, at least 2.
REQ-005 Parameter MAX_RETRY, default 2: resends allowed per command after a timeout, 0..7.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 push  in  1  enqueue {push_cmd, push_exp} this cycle.
REQ-009 push_cmd  in  CMD_W  command to send.
REQ-010 push_exp  in  RESP_W  expected response.
REQ-011 full  out  1  FIFO holds DEPTH entries.
REQ-012 start  in  1  begin draining the FIFO; ignored unless state is IDLE.
REQ-013 halt_on_err  in  1  1 = stop at first failure; 0 = log it and continue.
REQ-014 cmd  out  CMD_W  command to the remote-comm transmitter.
REQ-015 send_cmd  out  1  one-cycle send strobe.
REQ-016 cmd_sent  in  1  transmitter finished sending cmd.
REQ-017 resp_rdy  in  1  one-cycle strobe: resp valid.
REQ-018 resp  in  RESP_W  received response byte.
REQ-019 busy  out  1  state is not IDLE.
REQ-020 done  out  1  one-cycle strobe when a run ends.
REQ-021 pass  out  1  last run had zero failures; held until next start.
REQ-022 err_cnt  out  8  failures in the current run, saturating at 255.
REQ-023 err_code  out  2  first failure of the run: 00 none, 01 mismatch, 10 timeout, 11 retries exhausted.
REQ-024 cmd_idx  out  $clog2(DEPTH)+1  commands completed in the current run.

Function
REQ-025 FIFO: push while full is dropped and leaves the FIFO unchanged; push during busy is accepted if not full.
REQ-026 FIFO read pointer advances only on CHECK completion, so a retry resends the same entry.
REQ-027 States: IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, CHECK, FIN.
- IDLE -> LOAD on start.
- LOAD: if FIFO empty -> FIN; else latch head into cmd and exp_r -> SEND.
- SEND: assert send_cmd exactly one cycle -> WAIT_SENT.
- WAIT_SENT: on cmd_sent -> WAIT_RESP and clear the timeout counter.
- WAIT_RESP: on resp_rdy -> CHECK. If TMO_CYC cycles elapse with no resp_rdy: if retries < MAX_RETRY, retry count +1 -> SEND; else -> CHECK with flag exhausted.
- CHECK, one cycle: compare latched resp to exp_r (or apply exhausted), pop FIFO, cmd_idx +1, clear retry count. On failure, if halt_on_err -> FIN, else -> LOAD. On success -> LOAD.
- FIN: done = 1 for one cycle; pass = (err_cnt == 0) -> IDLE.
REQ-028 Latency from start to send_cmd high is 2 cycles when FIFO is non-empty.
REQ-029 resp_rdy outside WAIT_RESP is ignored; resp_rdy arriving in the same cycle as timeout expiry counts as a response.
REQ-030 A retry that later gets a response: a match counts as success; a mismatch counts as a failure with code 01. No timeout failure is logged for the earlier attempts.
REQ-031 Every exhausted-retry event counts as 1 failure in err_cnt, coded 11 if first. Intermediate timeouts that are retried are not counted.
REQ-032 err_code records only the first failure of a run; start clears err_cnt, err_code and cmd_idx.
REQ-033 A halt leaves the remaining entries in the FIFO; the next start resumes at the head.
REQ-034 cmd holds its value outside SEND; send_cmd is never high in two consecutive cycles.

Reset
REQ-035 rst asynchronously forces IDLE and an empty FIFO, with cmd=0, send_cmd=0, busy=0, done=0, pass=0, err_cnt=0, err_code=00, cmd_idx=0 and retry/timeout counters cleared. Reset mid-run discards the run with no done strobe.

Verification
REQ-036 Push {16'h2000, 8'hA5}, start, model returns A5 -> one send_cmd with cmd=2000, done, pass=1, err_cnt=0, cmd_idx=1.
REQ-037 Push 2000/A5 and 4BF1/A5, model returns A5 then 5A, halt_on_err=0 -> two sends, pass=0, err_cnt=1, err_code=01, cmd_idx=2.
REQ-038 Same stimulus as REQ-037 but halt_on_err=1 and the first response is 5A -> done after the first command, cmd_idx=1, FIFO still holds 4BF1; a second start sends 4BF1.
REQ-039 TMO_CYC=20, MAX_RETRY=2, model never responds -> 3 sends of the same cmd about 20 cycles apart, then err_code=11, err_cnt=1.
REQ-040 Push DEPTH+1 entries while idle -> full high after DEPTH pushes, last push dropped, run sends exactly DEPTH commands.
REQ-041 Assert rst during WAIT_RESP -> all outputs at reset values immediately with no clk edge, no done strobe, FIFO empty.
